fifo_gearbox_down: RTL and testbench
====================================

Name: fifo_gearbox_down

Overview:
Single-clock, width-reducing FIFO for the pSRAM write path. It accepts WR_W = RATIO*RD_W-bit words and returns them as RATIO consecutive RD_W-bit lanes in a programmable lane order. It generalises the fixed 32->16 hard-FIFO pair to parametrised width, ratio, depth and lane order. It adds programmable almost-empty/almost-full flags, a read-unit level count and sticky error flags. It sits between the MIPI pixel packer and the pSRAM write controller.

Parameters:
RD_W, 16, read lane width in bits (>=1)
RATIO, 2, read lanes per write word (>=2); WR_W = RATIO*RD_W
DEPTH, 512, storage depth in write words; power of two, >=2
LANE_ORDER, 0, 0 = lane 0 (wdata[RD_W-1:0]) read first; 1 = most significant lane read first
PE_THRESH, 4, prog_empty asserts when level <= PE_THRESH (read units)
PF_THRESH, DEPTH-4, prog_full asserts when stored words >= PF_THRESH

Ports:
clk  in  1  single clock for the write and read sides
reset  in  1  synchronous, active-high reset
wdata  in  RATIO*RD_W  write word
wen  in  1  write request; accepted only when wfull=0
wfull  out  1  DEPTH words occupied
rdata  out  RD_W  read lane, registered
ren  in  1  read request; accepted only when rempty=0
rempty  out  1  level == 0
prog_empty  out  1  level <= PE_THRESH
prog_full  out  1  word count >= PF_THRESH
level  out  $clog2(DEPTH*RATIO+1)  unread lanes = wcount*RATIO - lane_idx
overflow  out  1  sticky: wen seen while wfull=1
underflow  out  1  sticky: ren seen while rempty=1

Behaviour:
- State: storage array DEPTH x WR_W; wptr and rptr, each log2(DEPTH) bits, wrapping modulo DEPTH; wcount 0..DEPTH; lane_idx 0..RATIO-1 (lanes already consumed from the head word).
- Reset, at the clock edge with reset=1: wptr=rptr=wcount=lane_idx=0; rdata=0; overflow=underflow=0; rempty=1; prog_empty=1; wfull=0; prog_full=0; level=0. Reset overrides wen/ren in the same cycle. Reset mid-stream discards all data, including a partially read word.
- Flags and level are combinational from the registered state. They reflect accepted operations from the cycle after the edge.
- Write accepted (wen & !wfull): mem[wptr] <= wdata; wptr+1.
- Read accepted (ren & !rempty): rdata <= the selected lane of mem[rptr], registered, so data is valid the cycle after ren (1-cycle latency).
  - Lane select: lane_idx if LANE_ORDER=0; RATIO-1-lane_idx if LANE_ORDER=1.
  - If lane_idx == RATIO-1: lane_idx <= 0, rptr+1, and the word is freed.
  - Otherwise: lane_idx+1.
- rdata holds its value when no read is accepted.
- wcount update: +1 on an accepted write; -1 on an accepted read that frees a word; unchanged when both occur in the same cycle.
- A partially read head word still occupies its slot, so wfull stays asserted until its last lane is read.
- Simultaneous events:
  - Write at wfull=1 with a word-freeing read in the same cycle: the write is rejected, because wfull is evaluated before the edge; wfull deasserts next cycle.
  - Read at rempty=1 with a write: the read is rejected; rempty deasserts next cycle. There is no fall-through.
- Rejected wen sets overflow; rejected ren sets underflow. Both stay set until reset. State is unaffected.
- Pointer wrap is implicit in the modulo-DEPTH pointers; full and empty are distinguished by wcount, never by pointer equality.

Test Plan:
- Reset with wen/ren high -> all outputs 0 except rempty=1 and prog_empty=1; level=0.
- RD_W=8, RATIO=4, LANE_ORDER=0: write 0x44332211, then 4 reads -> rdata 0x11, 0x22, 0x33, 0x44 (each one cycle after ren); level 4,3,2,1,0; rempty=1 after the 4th read. Same stimulus with LANE_ORDER=1 -> 0x44, 0x33, 0x22, 0x11.
- DEPTH=16, RATIO=2: 16 writes -> wfull=1, level=32, prog_full=1 after the 12th write. A 17th write is dropped and sets overflow=1. Draining returns the first 16 words intact.
- Full FIFO, read lane 0 plus a write -> write dropped, wfull stays 1. Next cycle read lane 1 plus a write -> write dropped; wfull=0 afterwards. A write in the following cycle is accepted.
- Continuous write/read of 40 words with DEPTH=16 -> pointers wrap twice; the read sequence equals the written sequence; no error flags are set.
- ren on empty -> underflow=1, rdata unchanged. Three writes, one read, then reset -> level=0, rempty=1, flags cleared; a subsequent write/read returns only the new data.

Source files
------------

// File: rtl/fifo_gearbox_down.sv
// fifo_gearbox_down: single-clock width-reducing FIFO. Write words of
// RATIO*RD_W bits are read back as RATIO consecutive RD_W-bit lanes, in
// lane-0-first or most-significant-lane-first order. The level output counts
// unread lanes, and the error flags latch until reset.
module fifo_gearbox_down #(
    parameter  int RD_W       = 16,
    parameter  int RATIO      = 2,
    parameter  int DEPTH      = 512,
    parameter  int LANE_ORDER = 0,
    parameter  int PE_THRESH  = 4,
    parameter  int PF_THRESH  = DEPTH - 4,
    localparam int WR_W       = RATIO * RD_W,
    localparam int LW         = $clog2(DEPTH * RATIO + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WR_W-1:0] wdata,
    input  logic            wen,
    output logic            wfull,
    output logic [RD_W-1:0] rdata,
    input  logic            ren,
    output logic            rempty,
    output logic            prog_empty,
    output logic            prog_full,
    output logic [LW-1:0]   level,
    output logic            overflow,
    output logic            underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(RATIO);

    localparam logic [IW-1:0] LAST_LANE = IW'(RATIO - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [LW-1:0] PE_LVL    = LW'(PE_THRESH);
    localparam logic [CW-1:0] PF_CNT    = CW'(PF_THRESH);

    logic [WR_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_wcount;
    logic [IW-1:0]   r_lane_idx;
    logic [RD_W-1:0] r_rdata;
    logic            r_overflow;
    logic            r_underflow;

    logic                       w_wr_acc;
    logic                       w_rd_acc;
    logic                       w_last_lane;
    logic                       w_free;
    logic [IW-1:0]              w_sel;
    logic [RATIO-1:0][RD_W-1:0] w_lanes;
    logic [LW-1:0]              w_level;

    // Accept decisions use flags computed from state before the edge, so a
    // read that frees a slot cannot admit a write in the same cycle.
    assign w_wr_acc    = wen & ~wfull;
    assign w_rd_acc    = ren & ~rempty;
    assign w_last_lane = (r_lane_idx == LAST_LANE);
    assign w_free      = w_rd_acc & w_last_lane;

    // Lane mux over the head word. The packed view avoids explicit index math.
    assign w_lanes = r_mem[r_rptr];
    assign w_sel   = (LANE_ORDER != 0) ? (LAST_LANE - r_lane_idx) : r_lane_idx;

    // A partly read head word still holds its slot, so the level is the
    // number of stored words in lanes minus the lanes already consumed.
    assign w_level = LW'(r_wcount) * LW'(RATIO) - LW'(r_lane_idx);

    assign level      = w_level;
    assign rempty     = (w_level == '0);
    assign prog_empty = (w_level <= PE_LVL);
    assign wfull      = (r_wcount == FULL_CNT);
    assign prog_full  = (r_wcount >= PF_CNT);
    assign rdata      = r_rdata;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

    // Storage write. There is no reset because the contents are don't-care
    // until the pointers and count mark a slot valid.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_acc)
            r_mem[r_wptr] <= wdata;
    end

    // Pointers, lane index, occupancy, registered read lane and sticky errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_wcount    <= '0;
            r_lane_idx  <= '0;
            r_rdata     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc)
                r_wptr <= r_wptr + 1'b1;

            if (w_rd_acc) begin
                r_rdata <= w_lanes[w_sel];
                if (w_last_lane) begin
                    r_lane_idx <= '0;
                    r_rptr     <= r_rptr + 1'b1;
                end else begin
                    r_lane_idx <= r_lane_idx + 1'b1;
                end
            end

            case ({w_wr_acc, w_free})
                2'b10:   r_wcount <= r_wcount + 1'b1;
                2'b01:   r_wcount <= r_wcount - 1'b1;
                default: r_wcount <= r_wcount;
            endcase

            if (wen && wfull)
                r_overflow <= 1'b1;
            if (ren && rempty)
                r_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_gearbox_down.sv
// tb_fifo_gearbox_down: directed test of fifo_gearbox_down. Two 8-bit x4
// instances with opposite lane orders share their stimulus. A 16-bit x2,
// depth-16 instance is used for the full, wrap and error cases.
module tb_fifo_gearbox_down;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // group A: RD_W=8, RATIO=4, DEPTH=16, both lane orders
    logic        a_reset, a_wen, a_ren;
    logic [31:0] a_wdata;
    logic        a0_wfull, a0_rempty, a0_pe, a0_pf, a0_ovf, a0_unf;
    logic        a1_wfull, a1_rempty, a1_pe, a1_pf, a1_ovf, a1_unf;
    logic [7:0]  a0_rdata, a1_rdata;
    logic [6:0]  a0_level, a1_level;

    // group B: RD_W=16, RATIO=2, DEPTH=16, lane 0 first
    logic        b_reset, b_wen, b_ren;
    logic [31:0] b_wdata;
    logic        b_wfull, b_rempty, b_pe, b_pf, b_ovf, b_unf;
    logic [15:0] b_rdata;
    logic [5:0]  b_level;

    fifo_gearbox_down #(.RD_W(8), .RATIO(4), .DEPTH(16), .LANE_ORDER(0)) u_a0 (
        .clk(clk), .reset(a_reset), .wdata(a_wdata), .wen(a_wen), .wfull(a0_wfull),
        .rdata(a0_rdata), .ren(a_ren), .rempty(a0_rempty), .prog_empty(a0_pe),
        .prog_full(a0_pf), .level(a0_level), .overflow(a0_ovf), .underflow(a0_unf));

    fifo_gearbox_down #(.RD_W(8), .RATIO(4), .DEPTH(16), .LANE_ORDER(1)) u_a1 (
        .clk(clk), .reset(a_reset), .wdata(a_wdata), .wen(a_wen), .wfull(a1_wfull),
        .rdata(a1_rdata), .ren(a_ren), .rempty(a1_rempty), .prog_empty(a1_pe),
        .prog_full(a1_pf), .level(a1_level), .overflow(a1_ovf), .underflow(a1_unf));

    fifo_gearbox_down #(.RD_W(16), .RATIO(2), .DEPTH(16), .LANE_ORDER(0)) u_b (
        .clk(clk), .reset(b_reset), .wdata(b_wdata), .wen(b_wen), .wfull(b_wfull),
        .rdata(b_rdata), .ren(b_ren), .rempty(b_rempty), .prog_empty(b_pe),
        .prog_full(b_pf), .level(b_level), .overflow(b_ovf), .underflow(b_unf));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // one clock; outputs are sampled and inputs changed 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bword(input int i);
        return {16'h1000 + 16'(i), 16'h2000 + 16'(i)};
    endfunction

    logic [15:0] q[$];
    logic [15:0] exp_lane;
    logic [15:0] last_b;
    logic [7:0]  exp_a0[4];
    logic [7:0]  exp_a1[4];
    int          nw;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_a0 = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_a1 = '{8'h44, 8'h33, 8'h22, 8'h11};

        // reset with wen/ren held high
        a_reset = 1; a_wen = 1; a_ren = 1; a_wdata = 32'hFFFF_FFFF;
        b_reset = 1; b_wen = 1; b_ren = 1; b_wdata = 32'hFFFF_FFFF;
        tick(); tick();
        chk("rst_a_flags", {a0_rempty, a0_pe, a0_wfull, a0_pf, a0_ovf, a0_unf}, 6'b110000);
        chk("rst_a_level", a0_level, 0);
        chk("rst_a_rdata", a0_rdata, 0);
        chk("rst_b_flags", {b_rempty, b_pe, b_wfull, b_pf, b_ovf, b_unf}, 6'b110000);
        chk("rst_b_level", b_level, 0);
        chk("rst_b_rdata", b_rdata, 0);
        a_reset = 0; a_wen = 0; a_ren = 0;
        b_reset = 0; b_wen = 0; b_ren = 0;

        // lane order: one word, four lane reads
        a_wdata = 32'h4433_2211; a_wen = 1;
        tick();
        a_wen = 0;
        chk("a_level_w", a0_level, 4);
        chk("a_rempty_w", a0_rempty, 0);
        a_ren = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("a0_lane%0d", k), a0_rdata, exp_a0[k]);
            chk($sformatf("a1_lane%0d", k), a1_rdata, exp_a1[k]);
            chk($sformatf("a_level%0d", k), a0_level, 3 - k);
        end
        a_ren = 0;
        chk("a_rempty_end", a0_rempty, 1);
        chk("a_errs", {a0_ovf, a0_unf, a1_ovf, a1_unf}, 0);

        // fill depth-16 FIFO
        b_wen = 1;
        for (int i = 0; i < 16; i++) begin
            b_wdata = bword(i);
            tick();
            if (i == 10) chk("b_pf_11", b_pf, 0);
            if (i == 11) chk("b_pf_12", b_pf, 1);
        end
        chk("b_full", b_wfull, 1);
        chk("b_level_full", b_level, 32);
        b_wdata = 32'hDEAD_BEEF;
        tick();
        chk("b_ovf", b_ovf, 1);
        chk("b_level_ovf", b_level, 32);

        // full + partial read + write: both writes rejected
        b_ren = 1; b_wen = 1; b_wdata = 32'hBAD0_BAD0;
        tick();
        chk("b_rd_l0", b_rdata, 16'h2000);
        chk("b_full_l0", b_wfull, 1);
        chk("b_level_l0", b_level, 31);
        tick();
        chk("b_rd_l1", b_rdata, 16'h1000);
        chk("b_full_l1", b_wfull, 0);
        chk("b_level_l1", b_level, 30);
        b_ren = 0; b_wdata = bword(16);
        tick();
        b_wen = 0;
        chk("b_full_refill", b_wfull, 1);
        chk("b_level_refill", b_level, 32);

        // drain words 1..16
        b_ren = 1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("drain%0d_lo", i), b_rdata, 16'h2000 + 16'(i));
            tick();
            chk($sformatf("drain%0d_hi", i), b_rdata, 16'h1000 + 16'(i));
        end
        b_ren = 0;
        chk("drain_empty", b_rempty, 1);
        chk("drain_level", b_level, 0);

        // reset clears the sticky overflow
        b_reset = 1;
        tick();
        b_reset = 0;
        chk("rst2_ovf", b_ovf, 0);

        // streaming: 40 words, one write every other cycle, read when nonempty
        nw = 0;
        for (int cyc = 0; cyc < 400 && (nw < 40 || q.size() > 0); cyc++) begin
            b_wen = (cyc % 2 == 0) && (nw < 40);
            b_wdata = bword(100 + nw);
            b_ren = (q.size() > 0);
            tick();
            if (b_ren) begin
                exp_lane = q.pop_front();
                chk($sformatf("stream_c%0d", cyc), b_rdata, exp_lane);
            end
            if (b_wen) begin
                q.push_back(b_wdata[15:0]);
                q.push_back(b_wdata[31:16]);
                nw++;
            end
        end
        b_wen = 0; b_ren = 0;
        chk("stream_words", nw, 40);
        chk("stream_left", q.size(), 0);
        chk("stream_level", b_level, 0);
        chk("stream_errs", {b_ovf, b_unf}, 0);

        // underflow keeps rdata
        last_b = bword(139) >> 16;
        b_ren = 1;
        tick();
        b_ren = 0;
        chk("unf_set", b_unf, 1);
        chk("unf_rdata", b_rdata, last_b);

        // three writes, one read, then reset mid-stream
        b_wen = 1;
        for (int i = 0; i < 3; i++) begin
            b_wdata = bword(200 + i);
            tick();
        end
        b_wen = 0; b_ren = 1;
        tick();
        b_ren = 0;
        chk("mid_rd", b_rdata, 16'h2000 + 16'd200);
        chk("mid_level", b_level, 5);
        b_reset = 1;
        tick();
        b_reset = 0;
        chk("mid_rst_level", b_level, 0);
        chk("mid_rst_flags", {b_rempty, b_pe, b_wfull, b_pf, b_ovf, b_unf}, 6'b110000);
        chk("mid_rst_rdata", b_rdata, 0);
        b_wen = 1; b_wdata = 32'hCAFE_F00D;
        tick();
        b_wen = 0; b_ren = 1;
        tick();
        chk("new_lo", b_rdata, 16'hF00D);
        tick();
        b_ren = 0;
        chk("new_hi", b_rdata, 16'hCAFE);
        chk("new_empty", b_rempty, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
